uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
Buffered UART transmitter and the line-side counterpart of the team's receiver. It accepts bytes over a valid/ready handshake into a small synchronous FIFO. It then serialises each byte as 8N1 (start bit, 8 data bits LSB-first, stop bit) at BAUD_RATE, sending frames back-to-back while data is queued. It sits between the core logic and the tx output pin.

Parameters:
CLK_SPEED, 5_000_000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in baud
FIFO_DEPTH, 4, byte entries in the input FIFO; must be a power of two and at least 2
(derived localparams) BAUD_TICK = CLK_SPEED/BAUD_RATE (integer division); CNT_W = $clog2(BAUD_TICK); PTR_W = $clog2(FIFO_DEPTH)

Ports:
clock  input  1  system clock, all logic on the rising edge
reset  input  1  synchronous, active-high reset
data_in  input  8  byte to transmit
data_valid  input  1  data_in is valid this cycle
data_ready  output  1  FIFO can accept a byte this cycle
tx  output  1  serial line, idles high, registered output
busy  output  1  a frame is in progress or the FIFO is non-empty
fifo_count  output  PTR_W+1  number of bytes queued, excluding the frame in flight

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset. Reset state: tx=1, data_ready=1, busy=0, fifo_count=0, state=IDLE, bit counter=0, tick counter=0.
- Reset mid-frame: the frame is aborted, tx returns to 1 on the next edge, and FIFO contents are discarded.
- Handshake: data_ready = (fifo_count != FIFO_DEPTH), a combinational function of registered state only.
  - A push occurs when data_valid && data_ready at a rising edge.
  - data_in is ignored when no push occurs.
  - When full, no push is accepted even if a pop happens in the same cycle.
- FIFO: circular buffer with wrapping read/write pointers.
  - Simultaneous push and pop when not full and not empty: fifo_count is unchanged.
  - A pop from an empty FIFO never occurs.
- Serializer FSM states: IDLE, START, DATA, STOP (PARITY when the optional feature is enabled).
  - IDLE: tx=1. If the FIFO is non-empty: pop the head into the shift register, clear the tick counter, and go to START.
  - START: tx=0 for BAUD_TICK cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for BAUD_TICK cycles, then shift right and increment the bit index. After bit index 7 completes, go to STOP.
  - STOP: tx=1 for BAUD_TICK cycles. On the last cycle, if the FIFO is non-empty, pop and go straight to START with no idle gap; otherwise go to IDLE.
- Bit timing: the tick counter runs 0..BAUD_TICK-1 and wraps to 0 at each bit boundary. Every bit lasts exactly BAUD_TICK cycles, so a frame lasts exactly 10*BAUD_TICK cycles.
- Latency: a byte pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1; tx goes 0 after edge N+1.
- busy = (state != IDLE) || (fifo_count != 0).

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state sits between DATA and STOP and drives the even-parity bit (XOR of the 8 data bits) for BAUD_TICK cycles. The frame becomes 11*BAUD_TICK cycles.
- Undefined: the PARITY state and its logic are absent; 8N1 framing only.

Decomposition:
- Package uart_pkg holds:
  - the tx_state_t enum (IDLE, START, DATA, STOP, PARITY);
  - the function baud_ticks(clk, baud) returning CLK_SPEED/BAUD_RATE;
  - constants DATA_BITS=8, LINE_IDLE=1'b1, START_BIT=1'b0.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), instantiated with WIDTH=8, DEPTH=FIFO_DEPTH.

Test Plan (CLK_SPEED=16, BAUD_RATE=1, so BAUD_TICK=16; FIFO_DEPTH=4):
- Reset: hold reset for 3 cycles with data_valid=1 -> tx=1, data_ready=1, busy=0, fifo_count=0, and no push occurs.
- Single byte: push 0xA5 at cycle 10 -> tx=0 for cycles 11–26, then data bits 1,0,1,0,0,1,0,1 (16 cycles each), then stop=1 for 16 cycles; busy drops at cycle 171.
- Back-to-back: push 0x00 and 0xFF on consecutive cycles -> two 160-cycle frames with no idle cycle between the first stop and the second start.
- Full FIFO: hold data_valid with bytes 0x01..0x06 from idle -> 0x01 is in flight, 0x02..0x05 are queued, fifo_count=4, data_ready=0, and 0x06 stalls. When the 0x01 frame ends, 0x06 is accepted one cycle later, and output order is 0x01..0x06.
- Reset mid-frame: assert reset during data bit 3 of 0x3C -> tx=1 the next cycle, fifo_count=0, and the next frame after reset is complete and correct.
- Parity (with UART_TX_PARITY_EN defined): send 0x07 -> parity bit 1 before stop, 176-cycle frame; send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encoding, frame constants and the baud divisor helper.
package uart_pkg;

    localparam int   DATA_BITS = 8;
    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_t;

    // Clock cycles per bit on the line (integer division, truncating).
    function automatic int baud_ticks(input int clk, input int baud);
        return clk / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Small synchronous FIFO with wrapping read/write pointers. DEPTH must be a
// power of two so the pointers wrap naturally. The head entry is presented
// combinationally on dout while the FIFO is non-empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   cnt;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses a push even if a pop frees a slot in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (cnt == (PTR_W+1)'(DEPTH));
    assign empty = (cnt == '0);
    assign count = cnt;
    assign dout  = mem[rd_ptr];

    // Storage write; contents are don't-care until pushed, so no reset.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset discards all queued entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (PTR_W+1)'(1);
                2'b01:   cnt <= cnt - (PTR_W+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes enter a FIFO over a valid/ready handshake
// and leave LSB-first as 8N1 frames on a registered tx pin, back-to-back while
// data is queued. Defining UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit (8E1 framing).
module uart_tx_buffered #(
    parameter int CLK_SPEED  = 5_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    import uart_pkg::*;

    localparam int BAUD_TICK = baud_ticks(CLK_SPEED, BAUD_RATE);
    localparam int CNT_W     = (BAUD_TICK > 1) ? $clog2(BAUD_TICK) : 1;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(BAUD_TICK - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    tx_state_t        state;
    logic [CNT_W-1:0] tick_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             tx_reg;
    logic             tick_last;
    logic             push;
    logic             pop;
    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;

    assign tick_last  = (tick_cnt == TICK_LAST);
    assign data_ready = !fifo_full;
    assign push       = data_valid && data_ready;
    // The head is taken either from idle or on the final stop-bit cycle, so
    // queued bytes follow each other with no idle gap on the line.
    assign pop        = !fifo_empty &&
                        ((state == IDLE) || ((state == STOP) && tick_last));
    assign tx         = tx_reg;
    assign busy       = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Shift register loads on pop and moves one bit right after each data bit.
    always_ff @(posedge clock) begin
        if (pop) begin
            shift <= fifo_dout;
        end else if ((state == DATA) && tick_last) begin
            shift <= {1'b0, shift[7:1]};
        end
    end

`ifdef UART_TX_PARITY_EN
    logic parity;

    // Even parity is captured with the byte so it is ready after the data bits.
    always_ff @(posedge clock) begin
        if (pop) begin
            parity <= ^fifo_dout;
        end
    end
`endif

    // Serializer: tx is registered and loaded with the level of the state
    // being entered, so the line changes on the same edge as the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_idx  <= '0;
            tx_reg   <= LINE_IDLE;
        end else begin
            if ((state == IDLE) || tick_last) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end

            unique case (state)
                IDLE: begin
                    tx_reg <= LINE_IDLE;
                    if (!fifo_empty) begin
                        state  <= START;
                        tx_reg <= START_BIT;
                    end
                end
                START: begin
                    if (tick_last) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_reg  <= shift[0];
                    end
                end
                DATA: begin
                    if (tick_last) begin
                        if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state  <= PARITY;
                            tx_reg <= parity;
`else
                            state  <= STOP;
                            tx_reg <= LINE_IDLE;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_reg  <= shift[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick_last) begin
                        state  <= STOP;
                        tx_reg <= LINE_IDLE;
                    end
                end
`endif
                STOP: begin
                    if (tick_last) begin
                        if (!fifo_empty) begin
                            state  <= START;
                            tx_reg <= START_BIT;
                        end else begin
                            state  <= IDLE;
                            tx_reg <= LINE_IDLE;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_reg <= LINE_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with BAUD_TICK=16 and a 4-entry FIFO.
// Honours UART_TX_PARITY_EN so the same bench covers both framings.
module tb_uart_tx_buffered;

    localparam int BT = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_tx_buffered #(
        .CLK_SPEED  (16),
        .BAUD_RATE  (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected line bits, index 0 = start bit.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f = '0;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9] = ^d;
        f[10] = 1'b1;
`else
        f[9] = 1'b1;
`endif
        return f;
    endfunction

    // Samples NB bits of BT cycles each, starting with the current cycle.
    task automatic sample_bits(output logic [10:0] bits, output logic stable);
        bits = '0;
        stable = 1'b1;
        for (int b = 0; b < NB; b++) begin
            for (int s = 0; s < BT; s++) begin
                if (!(b == 0 && s == 0)) step();
                if (s == 0) bits[b] = tx;
                else if (tx !== bits[b]) stable = 1'b0;
            end
        end
    endtask

    task automatic wait_low(input int limit, output int waited);
        waited = 0;
        while (tx !== 1'b0 && waited < limit) begin
            step();
            waited++;
        end
        if (tx !== 1'b0) waited = -1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4000 && busy !== 1'b0; i++) step();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_timeout: busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        data_valid = 1'b1;
        data_in = 8'h5A;
        repeat (3) step();
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b want 1", tx); end
        checks++;
        if (data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", data_ready); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        reset = 1'b0;
        data_valid = 1'b0;
        repeat (4) step();
        checks++;
        if (fifo_count !== 3'd0 || tx !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_no_push: count=%0d tx=%b busy=%b want 0/1/0", fifo_count, tx, busy);
        end
    endtask

    task automatic test_single();
        logic [10:0] f;
        logic st;
        int push_cyc;
        data_in = 8'hA5;
        data_valid = 1'b1;
        step();
        push_cyc = cyc;
        data_valid = 1'b0;
        data_in = 8'hFF;
        checks++;
        if (fifo_count !== 3'd1 || busy !== 1'b1 || tx !== 1'b1) begin
            failures++;
            $display("FAIL single_push: count=%0d busy=%b tx=%b want 1/1/1", fifo_count, busy, tx);
        end
        step();
        checks++;
        if (tx !== 1'b0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL single_latency: tx=%b count=%0d want 0/0 one cycle after push", tx, fifo_count);
        end
        sample_bits(f, st);
        checks++;
        if (f !== exp_frame(8'hA5)) begin failures++; $display("FAIL single_frame: got %b want %b", f, exp_frame(8'hA5)); end
        checks++;
        if (st !== 1'b1) begin failures++; $display("FAIL single_bit_width: bits not stable for %0d cycles", BT); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_stop: got %b want 1", busy); end
        step();
        checks++;
        if (busy !== 1'b0 || tx !== 1'b1 || cyc != push_cyc + 1 + NB * BT) begin
            failures++;
            $display("FAIL single_end: busy=%b tx=%b cycle=%0d want 0/1/%0d", busy, tx, cyc, push_cyc + 1 + NB * BT);
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] f;
        logic st;
        int w;
        data_in = 8'h00;
        data_valid = 1'b1;
        step();
        data_in = 8'hFF;
        step();
        data_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'd1) begin failures++; $display("FAIL b2b_count: got %0d want 1", fifo_count); end
        wait_low(4, w);
        checks++;
        if (w != 0) begin failures++; $display("FAIL b2b_start: waited %0d want 0", w); end
        sample_bits(f, st);
        checks++;
        if (f !== exp_frame(8'h00) || st !== 1'b1) begin
            failures++;
            $display("FAIL b2b_frame0: got %b stable=%b want %b", f, st, exp_frame(8'h00));
        end
        step();
        checks++;
        if (tx !== 1'b0 || fifo_count !== 3'd0) begin
            failures++;
            $display("FAIL b2b_gap: tx=%b count=%0d want 0/0 right after stop", tx, fifo_count);
        end
        sample_bits(f, st);
        checks++;
        if (f !== exp_frame(8'hFF) || st !== 1'b1) begin
            failures++;
            $display("FAIL b2b_frame1: got %b stable=%b want %b", f, st, exp_frame(8'hFF));
        end
        step();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_end: busy=%b want 0", busy); end
    endtask

    task automatic test_full();
        logic [10:0] frames [6];
        logic        stab [6];
        int          acc6;
        int          start0;
        int          idx;
        for (int k = 0; k < 6; k++) begin
            frames[k] = '0;
            stab[k] = 1'b0;
        end
        acc6 = -1;
        start0 = -1000;
        idx = 0;
        fork
            begin
                logic rdy;
                data_valid = 1'b1;
                for (int n = 0; n < 400 && idx < 6; n++) begin
                    data_in = 8'(idx + 1);
                    rdy = data_ready;
                    step();
                    if (rdy) begin
                        if (idx == 5) acc6 = cyc;
                        idx++;
                    end
                    if (n == 8) begin
                        checks++;
                        if (fifo_count !== 3'd4 || data_ready !== 1'b0 || busy !== 1'b1 || tx !== 1'b0) begin
                            failures++;
                            $display("FAIL full_state: count=%0d ready=%b busy=%b tx=%b want 4/0/1/0",
                                     fifo_count, data_ready, busy, tx);
                        end
                    end
                end
                data_valid = 1'b0;
            end
            begin
                logic [10:0] f;
                logic st;
                int w;
                for (int k = 0; k < 6; k++) begin
                    wait_low(3 * NB * BT, w);
                    if (w < 0) break;
                    if (k == 0) start0 = cyc;
                    sample_bits(f, st);
                    frames[k] = f;
                    stab[k] = st;
                end
            end
        join
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (frames[k] !== exp_frame(8'(k + 1)) || stab[k] !== 1'b1) begin
                failures++;
                $display("FAIL full_order_%0d: got %b stable=%b want %b", k, frames[k], stab[k], exp_frame(8'(k + 1)));
            end
        end
        checks++;
        if (acc6 != start0 + NB * BT + 1) begin
            failures++;
            $display("FAIL full_accept6: cycle=%0d want %0d", acc6, start0 + NB * BT + 1);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        logic [10:0] f;
        logic st;
        int w;
        int lows;
        data_in = 8'h3C;
        data_valid = 1'b1;
        step();
        data_in = 8'h99;
        step();
        data_valid = 1'b0;
        // tx went low on the last edge; move into data bit 3 (offsets 64..79).
        repeat (69) step();
        checks++;
        if (tx !== 1'b1 || fifo_count !== 3'd1) begin
            failures++;
            $display("FAIL mid_before: tx=%b count=%0d want 1/1 in bit 3", tx, fifo_count);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (tx !== 1'b1 || fifo_count !== 3'd0 || busy !== 1'b0 || data_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: tx=%b count=%0d busy=%b ready=%b want 1/0/0/1", tx, fifo_count, busy, data_ready);
        end
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin failures++; $display("FAIL mid_aborted: %0d non-idle cycles want 0", lows); end
        data_in = 8'h5A;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        wait_low(4, w);
        checks++;
        if (w != 1) begin failures++; $display("FAIL mid_next_start: waited %0d want 1", w); end
        sample_bits(f, st);
        checks++;
        if (f !== exp_frame(8'h5A) || st !== 1'b1) begin
            failures++;
            $display("FAIL mid_next_frame: got %b stable=%b want %b", f, st, exp_frame(8'h5A));
        end
        wait_idle();
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [10:0] f;
        logic st;
        int w;
        int s0;
        data_in = 8'h07;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        wait_low(4, w);
        s0 = cyc;
        sample_bits(f, st);
        checks++;
        if (f[9] !== 1'b1 || f !== exp_frame(8'h07) || st !== 1'b1) begin
            failures++;
            $display("FAIL parity_07: got %b want %b", f, exp_frame(8'h07));
        end
        step();
        checks++;
        if (busy !== 1'b0 || cyc != s0 + 176) begin
            failures++;
            $display("FAIL parity_len: busy=%b cycle=%0d want 0/%0d", busy, cyc, s0 + 176);
        end
        data_in = 8'h03;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        wait_low(4, w);
        sample_bits(f, st);
        checks++;
        if (f[9] !== 1'b0 || f !== exp_frame(8'h03) || st !== 1'b1) begin
            failures++;
            $display("FAIL parity_03: got %b want %b", f, exp_frame(8'h03));
        end
        wait_idle();
    endtask
`endif

    initial begin
        test_reset();
        repeat (5) step();
        test_single();
        repeat (3) step();
        test_back_to_back();
        repeat (3) step();
        test_full();
        repeat (3) step();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        repeat (3) step();
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
